// File: rtl/boreal_vector_engine.sv
// INT8 vector multiply engine: streams packed 4xINT8 words from SRC and DST, requantizes the
// lane products and writes them back to DST. Define BOREAL_VEC_SAT_EN to saturate result lanes.
module boreal_vector_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        sram_rd_req,
    output logic [31:0] sram_rd_addr,
    input  logic [31:0] sram_rd_data,
    input  logic        sram_rd_ack,
    output logic        sram_wr_req,
    output logic [31:0] sram_wr_addr,
    output logic [31:0] sram_wr_data,
    input  logic        sram_wr_ack
);

    localparam logic [7:0] OffCmd    = 8'h00;
    localparam logic [7:0] OffSrc    = 8'h04;
    localparam logic [7:0] OffDst    = 8'h08;
    localparam logic [7:0] OffLen    = 8'h0C;
    localparam logic [7:0] OffScale  = 8'h10;
    localparam logic [7:0] OffZero   = 8'h14;
    localparam logic [7:0] OffAcc    = 8'h18;
    localparam logic [7:0] OffStatus = 8'h24;

    typedef enum logic [2:0] {
        StIdle,
        StRdA,
        StWaitA,
        StRdB,
        StWaitB,
        StCalc,
        StWr,
        StWaitWr
    } state_t;

    state_t      state;
    logic [31:0] src;
    logic [31:0] dst;
    logic [31:0] len;
    logic [31:0] scale;
    logic [31:0] zero;
    logic [31:0] acc;
    logic [31:0] idx;
    logic [31:0] a;
    logic [31:0] b;
    logic        done;

    logic        busy;
    logic        mmio_wr;
    logic        cfg_wr;
    logic        start;
    logic [31:0] idx_next;
    logic [31:0] word_off;
    logic [31:0] next_off;

    logic [31:0]        calc_word;
    logic [31:0]        calc_sum;
    logic signed [15:0] lane_p [4];
    logic signed [47:0] lane_s [4];
    logic signed [47:0] lane_y [4];

    logic unused_bits;

    assign busy     = (state != StIdle);
    assign mmio_wr  = sel & wr;
    assign cfg_wr   = mmio_wr & ~busy;
    assign start    = cfg_wr && (addr[7:0] == OffCmd) && wdata[0];
    assign idx_next = idx + 32'd1;
    assign word_off = idx << 2;
    assign next_off = idx_next << 2;
    assign ack      = sel;

    // Only the low result byte leaves the lane in the wrapping build.
    assign unused_bits = ^{addr[31:8], lane_y[0], lane_y[1], lane_y[2], lane_y[3]};

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr[7:0])
                OffSrc:    rdata = src;
                OffDst:    rdata = dst;
                OffLen:    rdata = len;
                OffScale:  rdata = scale;
                OffZero:   rdata = zero;
                OffAcc:    rdata = acc;
                OffStatus: rdata = {30'b0, done, busy};
                default:   rdata = '0;
            endcase
        end
    end

    always_comb begin
        calc_word = '0;
        calc_sum  = '0;
        for (int k = 0; k < 4; k++) begin
            lane_p[k] = '0;
            lane_s[k] = '0;
            lane_y[k] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            lane_p[k] = $signed({{8{a[8*k+7]}}, a[8*k +: 8]})
                      * $signed({{8{b[8*k+7]}}, b[8*k +: 8]});
            // Q16.16 scale: SCALE is unsigned, so it is zero-extended into the signed product.
            lane_s[k] = ($signed({{32{lane_p[k][15]}}, lane_p[k]})
                      * $signed({16'b0, scale})) >>> 16;
            lane_y[k] = lane_s[k] + $signed({{16{zero[31]}}, zero});
            calc_sum  = calc_sum + {{16{lane_p[k][15]}}, lane_p[k]};
`ifdef BOREAL_VEC_SAT_EN
            if (lane_y[k] > 48'sd127) begin
                calc_word[8*k +: 8] = 8'h7F;
            end else if (lane_y[k] < -48'sd128) begin
                calc_word[8*k +: 8] = 8'h80;
            end else begin
                calc_word[8*k +: 8] = lane_y[k][7:0];
            end
`else
            calc_word[8*k +: 8] = lane_y[k][7:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= StIdle;
            src          <= '0;
            dst          <= '0;
            len          <= '0;
            scale        <= '0;
            zero         <= '0;
            acc          <= '0;
            idx          <= '0;
            a            <= '0;
            b            <= '0;
            done         <= 1'b0;
            sram_rd_req  <= 1'b0;
            sram_rd_addr <= '0;
            sram_wr_req  <= 1'b0;
            sram_wr_addr <= '0;
            sram_wr_data <= '0;
        end else begin
            sram_rd_req <= 1'b0;
            sram_wr_req <= 1'b0;

            if (cfg_wr) begin
                case (addr[7:0])
                    OffSrc:   src   <= wdata;
                    OffDst:   dst   <= wdata;
                    OffLen:   len   <= wdata;
                    OffScale: scale <= wdata;
                    OffZero:  zero  <= wdata;
                    default:  ;
                endcase
            end

            // Requests are raised on entry to RD_A/RD_B/WR so each is high only in that state.
            case (state)
                StIdle: begin
                    if (start) begin
                        acc <= '0;
                        idx <= '0;
                        if (len == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            done         <= 1'b0;
                            state        <= StRdA;
                            sram_rd_req  <= 1'b1;
                            sram_rd_addr <= src;
                        end
                    end
                end
                StRdA: state <= StWaitA;
                StWaitA: begin
                    if (sram_rd_ack) begin
                        a            <= sram_rd_data;
                        state        <= StRdB;
                        sram_rd_req  <= 1'b1;
                        sram_rd_addr <= dst + word_off;
                    end
                end
                StRdB: state <= StWaitB;
                StWaitB: begin
                    if (sram_rd_ack) begin
                        b     <= sram_rd_data;
                        state <= StCalc;
                    end
                end
                StCalc: begin
                    acc          <= acc + calc_sum;
                    sram_wr_data <= calc_word;
                    sram_wr_addr <= dst + word_off;
                    sram_wr_req  <= 1'b1;
                    state        <= StWr;
                end
                StWr: state <= StWaitWr;
                StWaitWr: begin
                    if (sram_wr_ack) begin
                        idx <= idx_next;
                        if (idx_next == len) begin
                            state <= StIdle;
                            done  <= 1'b1;
                        end else begin
                            state        <= StRdA;
                            sram_rd_req  <= 1'b1;
                            sram_rd_addr <= src + next_off;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_boreal_vector_engine.sv
// Directed bench for boreal_vector_engine: table of single-word lane vectors plus hand-written
// sequences for start/busy interaction, LEN=0, cycle timing, slow acks and mid-run reset.
module tb_boreal_vector_engine;

    localparam logic [31:0] RCmd    = 32'h00;
    localparam logic [31:0] RSrc    = 32'h04;
    localparam logic [31:0] RDst    = 32'h08;
    localparam logic [31:0] RLen    = 32'h0C;
    localparam logic [31:0] RScale  = 32'h10;
    localparam logic [31:0] RZero   = 32'h14;
    localparam logic [31:0] RAcc    = 32'h18;
    localparam logic [31:0] RStatus = 32'h24;

`ifdef BOREAL_VEC_SAT_EN
    localparam logic [31:0] ExpBig = 32'h7F7F7F7F;
    localparam logic [31:0] ExpNeg = 32'hFFFFFF80;
`else
    localparam logic [31:0] ExpBig = 32'h01010101;
    localparam logic [31:0] ExpNeg = 32'hFFFFFF7F;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        ack;
    logic        sram_rd_req;
    logic [31:0] sram_rd_addr;
    logic [31:0] sram_rd_data = '0;
    logic        sram_rd_ack = 1'b0;
    logic        sram_wr_req;
    logic [31:0] sram_wr_addr;
    logic [31:0] sram_wr_data;
    logic        sram_wr_ack = 1'b0;

    always #5 clk = ~clk;

    boreal_vector_engine dut (
        .clk          (clk),
        .rst          (rst),
        .sel          (sel),
        .wr           (wr),
        .addr         (addr),
        .wdata        (wdata),
        .rdata        (rdata),
        .ack          (ack),
        .sram_rd_req  (sram_rd_req),
        .sram_rd_addr (sram_rd_addr),
        .sram_rd_data (sram_rd_data),
        .sram_rd_ack  (sram_rd_ack),
        .sram_wr_req  (sram_wr_req),
        .sram_wr_addr (sram_wr_addr),
        .sram_wr_data (sram_wr_data),
        .sram_wr_ack  (sram_wr_ack)
    );

    // SRAM model: word array covering byte addresses 0..0x1FC, fixed ack latency, write log.
    logic [31:0] mem [128];
    int          lat = 1;
    int          rd_total = 0;
    int          wr_total = 0;
    logic [31:0] wlog_addr [64];
    logic [31:0] wlog_data [64];
    logic        rpend = 1'b0;
    logic        wpend = 1'b0;
    int          rcnt = 0;
    int          wcnt = 0;
    logic [31:0] raddr = '0;
    logic [31:0] waddr = '0;
    logic [31:0] wdat = '0;

    always @(posedge clk) begin
        if (rst) begin
            sram_rd_ack <= 1'b0;
            sram_wr_ack <= 1'b0;
            rpend       <= 1'b0;
            wpend       <= 1'b0;
        end else begin
            sram_rd_ack <= 1'b0;
            sram_wr_ack <= 1'b0;
            if (rpend) begin
                if (rcnt == 0) begin
                    sram_rd_ack  <= 1'b1;
                    sram_rd_data <= mem[raddr[8:2]];
                    rpend        <= 1'b0;
                end else begin
                    rcnt <= rcnt - 1;
                end
            end
            if (sram_rd_req) begin
                rd_total <= rd_total + 1;
                if (lat <= 1) begin
                    sram_rd_ack  <= 1'b1;
                    sram_rd_data <= mem[sram_rd_addr[8:2]];
                end else begin
                    rpend <= 1'b1;
                    rcnt  <= lat - 2;
                    raddr <= sram_rd_addr;
                end
            end
            if (wpend) begin
                if (wcnt == 0) begin
                    sram_wr_ack                <= 1'b1;
                    wlog_addr[wr_total[5:0]]   <= waddr;
                    wlog_data[wr_total[5:0]]   <= wdat;
                    wr_total                   <= wr_total + 1;
                    wpend                      <= 1'b0;
                end else begin
                    wcnt <= wcnt - 1;
                end
            end
            if (sram_wr_req) begin
                if (lat <= 1) begin
                    sram_wr_ack              <= 1'b1;
                    wlog_addr[wr_total[5:0]] <= sram_wr_addr;
                    wlog_data[wr_total[5:0]] <= sram_wr_data;
                    wr_total                 <= wr_total + 1;
                end else begin
                    wpend <= 1'b1;
                    wcnt  <= lat - 2;
                    waddr <= sram_wr_addr;
                    wdat  <= sram_wr_data;
                end
            end
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic mmio_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        sel   = 1'b1;
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        sel = 1'b0;
        wr  = 1'b0;
    endtask

    task automatic mmio_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        sel  = 1'b1;
        wr   = 1'b0;
        addr = a;
        #1;
        d   = rdata;
        sel = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        mmio_read(a, d);
        check(name, d, exp);
    endtask

    task automatic wait_done(input string name);
        logic [31:0] s;
        int          n;
        n = 0;
        do begin
            mmio_read(RStatus, s);
            n++;
        end while (!s[1] && n < 2000);
        check(name, s, 32'h2);
    endtask

    task automatic configure(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l,
                             input logic [31:0] sc, input logic [31:0] z);
        mmio_write(RSrc, s);
        mmio_write(RDst, d);
        mmio_write(RLen, l);
        mmio_write(RScale, sc);
        mmio_write(RZero, z);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] scale;
        logic [31:0] zero;
        logic [31:0] exp_word;
        logic [31:0] exp_acc;
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] d;
        int          r0;
        int          w0;

        // a, b, scale, zero, expected word, expected ACC
        vecs[0] = '{32'h05040302, 32'h01010101, 32'h0000FFFF, 32'h0, 32'h04030201, 32'd14};
        vecs[1] = '{32'h7F7F7F7F, 32'h7F7F7F7F, 32'h00010000, 32'h0, ExpBig, 32'd64516};
        vecs[2] = '{32'h000000FE, 32'h00000003, 32'h00010000, 32'h0, 32'h000000FA, 32'hFFFFFFFA};
        vecs[3] = '{32'h01020304, 32'h01010101, 32'h00010000, 32'd5, 32'h06070809, 32'd10};
        vecs[4] = '{32'h80808080, 32'h01010101, 32'h00008000, 32'h0, 32'hC0C0C0C0, 32'hFFFFFE00};
        vecs[5] = '{32'h00000080, 32'h0000007F, 32'h00010000, 32'hFFFFFFFF, ExpNeg, 32'hFFFFC080};
        vecs[6] = '{32'h000000FF, 32'h00000001, 32'h00008000, 32'h0, 32'h000000FF, 32'hFFFFFFFF};
        for (int i = 0; i < 128; i++) mem[i] = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset rd_req", {31'b0, sram_rd_req}, 32'h0);
        check("reset wr_req", {31'b0, sram_wr_req}, 32'h0);
        for (int o = 0; o <= 'h24; o += 4) read_check($sformatf("reset reg 0x%0h", o), o, 32'h0);

        // Register readback, ack, sel=0 behaviour, unmapped offset
        mmio_write(RSrc, 32'hDEADBEE0);
        read_check("src readback pattern", RSrc, 32'hDEADBEE0);
        mmio_write(RZero, 32'hFFFFFFFB);
        read_check("zero readback pattern", RZero, 32'hFFFFFFFB);
        @(negedge clk);
        addr = RSrc;
        #1;
        check("rdata with sel=0", rdata, 32'h0);
        sel = 1'b1;
        #1;
        check("ack with sel=1", {31'b0, ack}, 32'h1);
        sel = 1'b0;
        read_check("unmapped 0x1c", 32'h1C, 32'h0);
        configure(32'h0, 32'h100, 32'd1, 32'hFFFF, 32'h0);
        read_check("src readback", RSrc, 32'h0);
        read_check("dst readback", RDst, 32'h100);
        read_check("len readback", RLen, 32'd1);
        read_check("scale readback", RScale, 32'hFFFF);
        read_check("zero readback", RZero, 32'h0);
        read_check("cmd reads 0", RCmd, 32'h0);
        read_check("status idle", RStatus, 32'h0);

        // Table of single-word vectors
        for (int i = 0; i < 7; i++) begin
            mem[0]  = vecs[i].a;
            mem[64] = vecs[i].b;
            configure(32'h0, 32'h100, 32'd1, vecs[i].scale, vecs[i].zero);
            w0 = wr_total;
            mmio_write(RCmd, 32'h1);
            if (i == 0) read_check("busy after start", RStatus, 32'h1);
            wait_done($sformatf("vec%0d done", i));
            check($sformatf("vec%0d write count", i), 32'(wr_total - w0), 32'd1);
            check($sformatf("vec%0d write addr", i), wlog_addr[w0[5:0]], 32'h100);
            check($sformatf("vec%0d write data", i), wlog_data[w0[5:0]], vecs[i].exp_word);
            read_check($sformatf("vec%0d acc", i), RAcc, vecs[i].exp_acc);
        end

        // Cycle timing: two words at 1-cycle ack latency take 14 cycles
        mem[0]  = 32'h01010101;
        mem[1]  = 32'h02020202;
        mem[64] = 32'h01010101;
        mem[65] = 32'h01010101;
        configure(32'h0, 32'h100, 32'd2, 32'h10000, 32'h0);
        mmio_write(RCmd, 32'h1);
        for (int k = 1; k <= 14; k++) begin
            mmio_read(RStatus, d);
            if (k == 13) check("len2 busy at cycle 13", d, 32'h1);
        end
        check("len2 done at cycle 14", d, 32'h2);
        read_check("len2 acc", RAcc, 32'd12);

        // LEN=0: immediate done, ACC cleared, no SRAM traffic
        mmio_write(RLen, 32'd0);
        r0 = rd_total;
        w0 = wr_total;
        mmio_write(RCmd, 32'h1);
        read_check("len0 status next cycle", RStatus, 32'h2);
        read_check("len0 acc cleared", RAcc, 32'h0);
        repeat (10) @(negedge clk);
        check("len0 no reads", 32'(rd_total - r0), 32'd0);
        check("len0 no writes", 32'(wr_total - w0), 32'd0);

        // LEN=4 with 3-cycle acks; CMD and SRC writes while busy must be ignored
        lat = 3;
        for (int j = 0; j < 4; j++) begin
            mem[j]      = 32'(32'h01010101 * (j + 1));
            mem[64 + j] = 32'h01010101;
            mem[16 + j] = 32'h7F7F7F7F;
        end
        configure(32'h0, 32'h100, 32'd4, 32'h10000, 32'h0);
        r0 = rd_total;
        w0 = wr_total;
        mmio_write(RCmd, 32'h1);
        read_check("len4 busy, done cleared", RStatus, 32'h1);
        repeat (5) @(negedge clk);
        mmio_write(RCmd, 32'h1);
        mmio_write(RSrc, 32'h40);
        wait_done("len4 done");
        check("len4 write count", 32'(wr_total - w0), 32'd4);
        check("len4 read count", 32'(rd_total - r0), 32'd8);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("len4 word%0d addr", j), wlog_addr[6'(w0 + j)], 32'(32'h100 + 4 * j));
            check($sformatf("len4 word%0d data", j), wlog_data[6'(w0 + j)],
                  32'(32'h01010101 * (j + 1)));
        end
        read_check("len4 acc", RAcc, 32'd40);
        read_check("src write ignored while busy", RSrc, 32'h0);

        // Reset in the middle of a run
        lat = 1;
        mmio_write(RCmd, 32'h1);
        repeat (10) @(negedge clk);
        read_check("midrun busy", RStatus, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrun rst rd_req", {31'b0, sram_rd_req}, 32'h0);
        check("midrun rst wr_req", {31'b0, sram_wr_req}, 32'h0);
        check("midrun rst rd_addr", sram_rd_addr, 32'h0);
        read_check("midrun rst status", RStatus, 32'h0);
        read_check("midrun rst dst", RDst, 32'h0);
        read_check("midrun rst len", RLen, 32'h0);
        read_check("midrun rst acc", RAcc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
